alu_seq: RTL



---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with iterative shift-add multiply: 1-cycle latency, WIDTH cycles for MUL.
// Single outstanding op; start is ignored while busy, and there is no queuing or backpressure beyond busy.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         opcode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   incr;
    logic [RW-1:0]    res;
    logic             res_carry;
    logic             res_err;
    logic [RW-1:0]    acc_nxt;
    logic             mul_last;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};
    assign incr = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle result path for every opcode except MUL.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res       = {{(WIDTH-1){1'b0}}, sum};
                res_carry = sum[WIDTH];
            end
            OP_SUB: begin
                // diff[WIDTH] is both the borrow and the sign of the true difference.
                res       = {{WIDTH{diff[WIDTH]}}, diff[WIDTH-1:0]};
                res_carry = diff[WIDTH];
            end
            OP_MUL: begin
                res = '0;
            end
            OP_INC: begin
                res       = {{(WIDTH-1){1'b0}}, incr};
                res_carry = incr[WIDTH];
            end
            OP_AND: res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:  res = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR: res = {{WIDTH{1'b0}}, a_q ^ b_q};
            default: begin
                res     = '0;
                res_err = 1'b1;
            end
        endcase
    end

    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= opcode;
                        busy <= 1'b1;
                        if (opcode == OP_MUL) begin
                            state  <= MUL;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    out   <= res;
                    carry <= res_carry;
                    zero  <= (res == '0);
                    err   <= res_err;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                MUL: begin
                    // One multiplier bit per cycle, LSB first; out only sees the final sum.
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (mul_last) begin
                        out   <= acc_nxt;
                        carry <= 1'b0;
                        zero  <= (acc_nxt == '0);
                        err   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
